// File: rtl/fifo_ser_pkg.sv
// fifo_ser_pkg: shared types and constants for the FIFO-draining serializer.
//   ser_state_t          : serializer FSM state encoding
//   DEFAULT_DATA_WIDTH   : default FIFO word / serial data field width
//   DEFAULT_CLKS_PER_BIT : default clk cycles per serial bit
//   frame_len()          : clk cycles in one serial frame
// Optional feature macro: FIFO_SER_PARITY_EN (adds an even-parity bit).
package fifo_ser_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 15;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

`ifdef FIFO_SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_SER_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } ser_state_t;

  // Start + data + optional parity + stop, each CLKS_PER_BIT cycles long.
  function automatic int frame_len(input int data_width, input int clks_per_bit);
    return (data_width + 2 + PARITY_BITS) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: FIFO read port plus serial-side status of the serializer.
//   en         : permission to start new frames
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO pop request (one-cycle pulse)
//   fifo_data  : FIFO data_out, valid the cycle after fifo_rd_en
//   ser_out    : serial line, idles high
//   busy       : frame in progress (POP through STOP)
//   word_done  : pulse on the final STOP cycle
// Modports: master = serializer side, slave = FIFO / environment side.
interface fifo_serializer_if import fifo_ser_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  en;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  ser_out;
  logic                  busy;
  logic                  word_done;

  modport master (
    input  en, fifo_empty, fifo_data,
    output fifo_rd_en, ser_out, busy, word_done
  );

  modport slave (
    output en, fifo_empty, fifo_data,
    input  fifo_rd_en, ser_out, busy, word_done
  );

endinterface

// File: rtl/fifo_serializer_bit_timer.sv
// ser_bit_timer: bit-period tick counter for the serializer.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : hold the counter at zero (between frames)
//   bit_end      : high on the last cycle of each bit period
//   bit_end_next : bit_end as it will be in the next cycle (for registered outputs)
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_r;
  logic [TW-1:0] tick_nxt_s;

  // Next tick: cleared on request, wraps to zero at the end of a bit period.
  always_comb begin
    tick_nxt_s = '0;
    if (clr) begin
      tick_nxt_s = '0;
    end else if (tick_r == TICK_LAST) begin
      tick_nxt_s = '0;
    end else begin
      tick_nxt_s = tick_r + TW'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= '0;
    end else begin
      tick_r <= tick_nxt_s;
    end
  end

  assign bit_end      = (tick_r == TICK_LAST);
  assign bit_end_next = (tick_nxt_s == TICK_LAST);

endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from a synchronous FIFO and sends each as an
// async serial frame (start bit, DATA_WIDTH data bits LSB first, optional
// even-parity bit, stop bit), each bit CLKS_PER_BIT clk cycles long.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_serializer_if.master (en, FIFO read port, ser_out, busy, word_done)
// Optional feature macro: FIFO_SER_PARITY_EN (PARITY state between DATA and STOP).
module fifo_serializer import fifo_ser_pkg::*; #(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic               clk,
  input logic               rst,
  fifo_serializer_if.master bus
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  ser_state_t            state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [BW-1:0]         bitcnt_r, bitcnt_nxt_s;
  logic                  fifo_rd_en_r, ser_out_r, busy_r, word_done_r;
  logic                  ser_out_nxt_s;
  logic                  timer_clr_s, bit_end_s, bit_end_next_s;

`ifdef FIFO_SER_PARITY_EN
  logic par_r, par_nxt_s;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // The bit timer only runs while a bit is on the line.
  assign timer_clr_s = (state_r == IDLE) || (state_r == POP) || (state_r == LOAD);

  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clr          (timer_clr_s),
    .bit_end      (bit_end_s),
    .bit_end_next (bit_end_next_s)
  );

  // Next-state, shift register and bit counter logic.
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
`ifdef FIFO_SER_PARITY_EN
    par_nxt_s    = par_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.en && !bus.fifo_empty) state_nxt_s = POP;
        else                           state_nxt_s = IDLE;
      end
      POP: state_nxt_s = LOAD;
      LOAD: begin
        shreg_nxt_s  = bus.fifo_data;
        bitcnt_nxt_s = '0;
`ifdef FIFO_SER_PARITY_EN
        par_nxt_s    = even_parity(bus.fifo_data);
`endif
        state_nxt_s  = START;
      end
      START: begin
        if (bit_end_s) state_nxt_s = DATA;
        else           state_nxt_s = START;
      end
      DATA: begin
        if (bit_end_s) begin
          shreg_nxt_s = shreg_r >> 1;
          if (bitcnt_r == BIT_LAST) begin
            bitcnt_nxt_s = '0;
`ifdef FIFO_SER_PARITY_EN
            state_nxt_s  = PARITY;
`else
            state_nxt_s  = STOP;
`endif
          end else begin
            bitcnt_nxt_s = bitcnt_r + BW'(1);
            state_nxt_s  = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef FIFO_SER_PARITY_EN
      PARITY: begin
        if (bit_end_s) state_nxt_s = STOP;
        else           state_nxt_s = PARITY;
      end
`endif
      STOP: begin
        // Last stop cycle doubles as the frame boundary where en/empty are sampled.
        if (bit_end_s) begin
          if (bus.en && !bus.fifo_empty) state_nxt_s = POP;
          else                           state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Line level for the next cycle, decoded from next state so ser_out is a flop.
  always_comb begin
    ser_out_nxt_s = 1'b1;
    case (state_nxt_s)
      START:   ser_out_nxt_s = 1'b0;
      DATA:    ser_out_nxt_s = shreg_nxt_s[0];
`ifdef FIFO_SER_PARITY_EN
      PARITY:  ser_out_nxt_s = par_nxt_s;
`endif
      default: ser_out_nxt_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      bitcnt_r     <= '0;
`ifdef FIFO_SER_PARITY_EN
      par_r        <= 1'b0;
`endif
      fifo_rd_en_r <= 1'b0;
      ser_out_r    <= 1'b1;
      busy_r       <= 1'b0;
      word_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shreg_r      <= shreg_nxt_s;
      bitcnt_r     <= bitcnt_nxt_s;
`ifdef FIFO_SER_PARITY_EN
      par_r        <= par_nxt_s;
`endif
      fifo_rd_en_r <= (state_nxt_s == POP);
      ser_out_r    <= ser_out_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      word_done_r  <= (state_nxt_s == STOP) && bit_end_next_s;
    end
  end

  assign bus.fifo_rd_en = fifo_rd_en_r;
  assign bus.ser_out    = ser_out_r;
  assign bus.busy       = busy_r;
  assign bus.word_done  = word_done_r;

endmodule
